// File: rtl/xbar_switch_rr_if.sv
// Port bundle for xbar_switch_rr: per-input transmit side and per-output receive side.
// The slave modport is the crossbar's view; master is the surrounding port logic.
interface xbar_switch_rr_if #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned SEL_W = $clog2(N_PORTS);

  logic [N_PORTS*DATA_W-1:0] port_tx_data;
  logic [N_PORTS*SEL_W-1:0]  port_tx_dest;
  logic [N_PORTS-1:0]        port_tx_last;
  logic [N_PORTS-1:0]        port_tx_valid;
  logic [N_PORTS-1:0]        port_tx_ready;
  logic [N_PORTS*DATA_W-1:0] port_rx_data;
  logic [N_PORTS-1:0]        port_rx_last;
  logic [N_PORTS-1:0]        port_rx_valid;
  logic [N_PORTS-1:0]        port_rx_ready;

  modport master (
    output port_tx_data,
    output port_tx_dest,
    output port_tx_last,
    output port_tx_valid,
    input  port_tx_ready,
    input  port_rx_data,
    input  port_rx_last,
    input  port_rx_valid,
    output port_rx_ready
  );

  modport slave (
    input  port_tx_data,
    input  port_tx_dest,
    input  port_tx_last,
    input  port_tx_valid,
    output port_tx_ready,
    output port_rx_data,
    output port_rx_last,
    output port_rx_valid,
    input  port_rx_ready
  );
endinterface

// File: rtl/xbar_switch_rr.sv
// Registered N-port crossbar with per-output round-robin arbitration and valid/ready flow.
// Define XBAR_PKT_LOCK_EN to hold each output on one input until that input's last beat.
module xbar_switch_rr #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8
) (
  input logic             clk,
  input logic             rst,
  xbar_switch_rr_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_PORTS);
  localparam logic [SEL_W:0] NPorts = (SEL_W+1)'(N_PORTS);

`ifdef XBAR_PKT_LOCK_EN
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]       state_q    [N_PORTS];
  logic [0:0]       state_d    [N_PORTS];
  logic [SEL_W-1:0] lock_src_q [N_PORTS];
  logic [SEL_W-1:0] lock_src_d [N_PORTS];
`endif

  // Unpacked views of the flattened input buses
  logic [DATA_W-1:0]  tx_data [N_PORTS];
  logic [SEL_W-1:0]   tx_dest [N_PORTS];
  logic [N_PORTS-1:0] tx_oor;

  // req[j][i]: input i wants output j
  logic [N_PORTS-1:0] req     [N_PORTS];
  logic [SEL_W-1:0]   gnt_idx [N_PORTS];
  logic [N_PORTS-1:0] gnt_any;
  logic [N_PORTS-1:0] can_load;
  logic [N_PORTS-1:0] xfer;
  logic [N_PORTS-1:0] tx_ready;

  logic [DATA_W-1:0]  rx_data_q  [N_PORTS];
  logic [DATA_W-1:0]  rx_data_d  [N_PORTS];
  logic [N_PORTS-1:0] rx_last_q;
  logic [N_PORTS-1:0] rx_last_d;
  logic [N_PORTS-1:0] rx_valid_q;
  logic [N_PORTS-1:0] rx_valid_d;
  logic [SEL_W-1:0]   rr_ptr_q   [N_PORTS];
  logic [SEL_W-1:0]   rr_ptr_d   [N_PORTS];

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      tx_data[i] = bus.port_tx_data[i*DATA_W +: DATA_W];
      tx_dest[i] = bus.port_tx_dest[i*SEL_W +: SEL_W];
      tx_oor[i]  = ({1'b0, tx_dest[i]} >= NPorts);
    end
  end

  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      req[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        req[j][i] = bus.port_tx_valid[i] && (tx_dest[i] == SEL_W'(j));
      end
      can_load[j] = !rx_valid_q[j] || bus.port_rx_ready[j];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo N_PORTS
  always_comb begin
    logic [SEL_W:0] cand;
    cand = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      gnt_any[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        cand = {1'b0, rr_ptr_q[j]} + (SEL_W+1)'(k);
        if (cand >= NPorts) begin
          cand = cand - NPorts;
        end
        if (!gnt_any[j] && req[j][cand[SEL_W-1:0]]) begin
          gnt_any[j] = 1'b1;
          gnt_idx[j] = cand[SEL_W-1:0];
        end
      end
`ifdef XBAR_PKT_LOCK_EN
      // A locked output only listens to the packet owner, bubbles included
      if (state_q[j] == StLocked) begin
        gnt_any[j] = req[j][lock_src_q[j]];
        gnt_idx[j] = lock_src_q[j];
      end
`endif
      xfer[j] = gnt_any[j] && can_load[j];
    end
  end

  // Out-of-range beats are swallowed so a bad destination cannot wedge its input
  always_comb begin
    tx_ready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      tx_ready[i] = bus.port_tx_valid[i] && tx_oor[i];
      for (int j = 0; j < N_PORTS; j++) begin
        if (xfer[j] && (gnt_idx[j] == SEL_W'(i))) begin
          tx_ready[i] = 1'b1;
        end
      end
    end
    if (rst) begin
      tx_ready = '0;
    end
  end

  always_comb begin
    logic [SEL_W:0] ptr_nxt;
    ptr_nxt    = '0;
    rx_last_d  = rx_last_q;
    rx_valid_d = rx_valid_q;
    for (int j = 0; j < N_PORTS; j++) begin
      rx_data_d[j] = rx_data_q[j];
      rr_ptr_d[j]  = rr_ptr_q[j];
`ifdef XBAR_PKT_LOCK_EN
      state_d[j]    = state_q[j];
      lock_src_d[j] = lock_src_q[j];
`endif
      if (xfer[j]) begin
        rx_data_d[j]  = tx_data[gnt_idx[j]];
        rx_last_d[j]  = bus.port_tx_last[gnt_idx[j]];
        rx_valid_d[j] = 1'b1;
      end else if (bus.port_rx_ready[j]) begin
        rx_valid_d[j] = 1'b0;
      end

      ptr_nxt = {1'b0, gnt_idx[j]} + (SEL_W+1)'(1);
      if (ptr_nxt >= NPorts) begin
        ptr_nxt = '0;
      end

`ifdef XBAR_PKT_LOCK_EN
      // Fairness only moves at packet boundaries
      if (xfer[j]) begin
        if (bus.port_tx_last[gnt_idx[j]]) begin
          state_d[j]  = StIdle;
          rr_ptr_d[j] = ptr_nxt[SEL_W-1:0];
        end else begin
          state_d[j]    = StLocked;
          lock_src_d[j] = gnt_idx[j];
        end
      end
`else
      if (xfer[j]) begin
        rr_ptr_d[j] = ptr_nxt[SEL_W-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_last_q  <= '0;
      rx_valid_q <= '0;
      for (int j = 0; j < N_PORTS; j++) begin
        rx_data_q[j] <= '0;
        rr_ptr_q[j]  <= '0;
`ifdef XBAR_PKT_LOCK_EN
        state_q[j]    <= StIdle;
        lock_src_q[j] <= '0;
`endif
      end
    end else begin
      rx_last_q  <= rx_last_d;
      rx_valid_q <= rx_valid_d;
      for (int j = 0; j < N_PORTS; j++) begin
        rx_data_q[j] <= rx_data_d[j];
        rr_ptr_q[j]  <= rr_ptr_d[j];
`ifdef XBAR_PKT_LOCK_EN
        state_q[j]    <= state_d[j];
        lock_src_q[j] <= lock_src_d[j];
`endif
      end
    end
  end

  always_comb begin
    bus.port_rx_data = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      bus.port_rx_data[j*DATA_W +: DATA_W] = rx_data_q[j];
    end
  end

  assign bus.port_rx_last  = rx_last_q;
  assign bus.port_rx_valid = rx_valid_q;
  assign bus.port_tx_ready = tx_ready;

endmodule

// File: tb/tb_xbar_switch_rr.sv
// Directed bench for xbar_switch_rr: vector table on a 4-port instance plus
// hand-written packet-lock, reset-mid-packet and out-of-range sequences (3-port instance).
module tb_xbar_switch_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_switch_rr_if #(.N_PORTS(4), .DATA_W(8)) if4 ();
  xbar_switch_rr_if #(.N_PORTS(3), .DATA_W(8)) if3 ();

  xbar_switch_rr #(.N_PORTS(4), .DATA_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  xbar_switch_rr #(.N_PORTS(3), .DATA_W(8)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dest;
    logic [3:0]  valid;
    logic [3:0]  rx_ready;
    logic [3:0]  exp_tx_ready;
    logic [3:0]  exp_rx_valid;
    logic [31:0] exp_rx_data;
  } vec_t;

  vec_t vecs [16];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] v);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) begin
      if (v[j]) m[j*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  logic [7:0]  expa [5];
  logic [3:0]  rdy;
  logic [31:0] msk;
  int k0;
  int k3;

  initial begin
    // data, dest, valid, rx_ready, exp_tx_ready, exp_rx_valid, exp_rx_data
    vecs[0] = '{32'h13121110, 8'h1B, 4'hF, 4'hF, 4'hF, 4'hF, 32'h10111213};
    vecs[1] = '{32'h23222120, 8'h1B, 4'hF, 4'hF, 4'hF, 4'hF, 32'h20212223};
    for (int v = 0; v < 6; v++) begin
      vecs[2+v] = '{32'h00323130, 8'h15, 4'b0111, 4'hF, 4'(1 << (v % 3)), 4'b0010,
                    32'(32'h00003000 + ((v % 3) << 8))};
    end
    vecs[8] = '{32'h0000A500, 8'h08, 4'b0010, 4'hF, 4'b0010, 4'b0100, 32'h00A50000};
    for (int v = 9; v < 14; v++) begin
      vecs[v] = '{32'h00005A00, 8'h08, 4'b0010, 4'b1011, 4'b0000, 4'b0100, 32'h00A50000};
    end
    vecs[14] = '{32'h00005A00, 8'h08, 4'b0010, 4'hF, 4'b0010, 4'b0100, 32'h005A0000};
    vecs[15] = '{32'h00000000, 8'h00, 4'b0000, 4'hF, 4'b0000, 4'b0000, 32'h00000000};

    // Reset with every input requesting: nothing may be accepted
    if4.port_tx_data  = 32'h44332211;
    if4.port_tx_dest  = 8'h1B;
    if4.port_tx_last  = 4'hF;
    if4.port_tx_valid = 4'hF;
    if4.port_rx_ready = 4'hF;
    if3.port_tx_data  = '0;
    if3.port_tx_dest  = '0;
    if3.port_tx_last  = '0;
    if3.port_tx_valid = '0;
    if3.port_rx_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", 32'(if4.port_tx_ready), 32'h0);
    chk("rst_rx_valid", 32'(if4.port_rx_valid), 32'h0);
    chk("rst_rx_last", 32'(if4.port_rx_last), 32'h0);
    chk("rst_rx_data", if4.port_rx_data, 32'h0);
    chk("rst3_rx_valid", 32'(if3.port_rx_valid), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    if4.port_tx_valid = 4'h0;

    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      if4.port_tx_data  = vecs[v].data;
      if4.port_tx_dest  = vecs[v].dest;
      if4.port_tx_last  = 4'hF;
      if4.port_tx_valid = vecs[v].valid;
      if4.port_rx_ready = vecs[v].rx_ready;
      #1;
      chk($sformatf("vec%0d_tx_ready", v), 32'(if4.port_tx_ready), 32'(vecs[v].exp_tx_ready));
      @(posedge clk);
      #1;
      msk = lane_mask(vecs[v].exp_rx_valid);
      chk($sformatf("vec%0d_rx_valid", v), 32'(if4.port_rx_valid), 32'(vecs[v].exp_rx_valid));
      chk($sformatf("vec%0d_rx_data", v), if4.port_rx_data & msk, vecs[v].exp_rx_data);
      chk($sformatf("vec%0d_rx_last", v), 32'(if4.port_rx_last & vecs[v].exp_rx_valid),
          32'(vecs[v].exp_rx_valid));
    end

    // Input 0 sends a 4-beat packet to output 0 while input 3 keeps requesting it
`ifdef XBAR_PKT_LOCK_EN
    expa[0] = 8'h40; expa[1] = 8'h41; expa[2] = 8'h42; expa[3] = 8'h43; expa[4] = 8'hD0;
`else
    expa[0] = 8'h40; expa[1] = 8'hD0; expa[2] = 8'h41; expa[3] = 8'hD1; expa[4] = 8'h42;
`endif
    k0 = 0;
    k3 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if4.port_tx_data  = {8'(8'hD0 + k3), 16'h0, 8'(8'h40 + k0)};
      if4.port_tx_dest  = 8'h00;
      if4.port_tx_last  = {1'b1, 2'b00, (k0 == 3)};
      if4.port_tx_valid = {1'b1, 2'b00, (k0 < 4)};
      if4.port_rx_ready = 4'hF;
      #1;
      rdy = if4.port_tx_ready;
      @(posedge clk);
      #1;
      chk($sformatf("pkt%0d_out0_valid", c), 32'(if4.port_rx_valid[0]), 32'h1);
      chk($sformatf("pkt%0d_out0_data", c), 32'(if4.port_rx_data[7:0]), 32'(expa[c]));
      if (rdy[0]) k0++;
      if (rdy[3]) k3++;
    end

    @(negedge clk);
    if4.port_tx_valid = 4'h0;
    @(posedge clk);

    // Reset lands on beat 2 of a packet from input 0 to output 0
    @(negedge clk);
    if4.port_tx_data  = 32'h00000060;
    if4.port_tx_dest  = 8'h00;
    if4.port_tx_last  = 4'b0000;
    if4.port_tx_valid = 4'b0001;
    #1;
    chk("rstpkt_beat1_tx_ready", 32'(if4.port_tx_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("rstpkt_beat1_data", 32'(if4.port_rx_data[7:0]), 32'h60);
    @(negedge clk);
    rst = 1'b1;
    if4.port_tx_data  = 32'hE0000061;
    if4.port_tx_last  = 4'b1000;
    if4.port_tx_valid = 4'b1001;
    #1;
    chk("rstpkt_rst_tx_ready", 32'(if4.port_tx_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rstpkt_rx_valid", 32'(if4.port_rx_valid), 32'h0);
    chk("rstpkt_rx_data", if4.port_rx_data, 32'h0);
    chk("rstpkt3_rx_valid", 32'(if3.port_rx_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    if4.port_tx_valid = 4'b1000;
    #1;
    chk("rstpkt_in3_tx_ready", 32'(if4.port_tx_ready), 32'h8);
    @(posedge clk);
    #1;
    chk("rstpkt_in3_valid", 32'(if4.port_rx_valid), 32'h1);
    chk("rstpkt_in3_data", 32'(if4.port_rx_data[7:0]), 32'hE0);
    @(negedge clk);
    if4.port_tx_valid = 4'h0;

    // 3-port instance: input 1 targets nonexistent output 3, input 2 targets output 0
    if3.port_tx_data  = 24'hC2C100;
    if3.port_tx_dest  = 6'b00_11_00;
    if3.port_tx_last  = 3'b111;
    if3.port_tx_valid = 3'b110;
    #1;
    chk("oor_mix_tx_ready", 32'(if3.port_tx_ready), 32'h6);
    @(posedge clk);
    #1;
    chk("oor_mix_rx_valid", 32'(if3.port_rx_valid), 32'h1);
    chk("oor_mix_rx_data", 32'(if3.port_rx_data[7:0]), 32'hC2);
    @(negedge clk);
    if3.port_tx_valid = 3'b010;
    #1;
    chk("oor_only_tx_ready", 32'(if3.port_tx_ready), 32'h2);
    @(posedge clk);
    #1;
    chk("oor_only_rx_valid", 32'(if3.port_rx_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xbar_switch_rr.md
# xbar_switch_rr

Parametrised N-port registered crossbar with per-output round-robin arbitration and valid/ready flow control. It is the next generation of the team's static 4x4 mux crossbar. Each input beat carries its own destination index, so no external select bus is needed. Contention for an output is resolved in hardware, and packets can optionally be held together across multiple beats. The block sits between the port transmit logic and the port receive logic, with one registered output stage per port.

## Interface
Parameters:
- N_PORTS, 4, number of input ports and of output ports (2..16).
- DATA_W, 8, data bits per beat.
- SEL_W, $clog2(N_PORTS), destination index width; derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- port_tx_data  in  N_PORTS*DATA_W  input i data at [i*DATA_W +: DATA_W].
- port_tx_dest  in  N_PORTS*SEL_W  input i destination output index at [i*SEL_W +: SEL_W].
- port_tx_last  in  N_PORTS  input i final beat of a packet.
- port_tx_valid  in  N_PORTS  input i beat present.
- port_tx_ready  out  N_PORTS  input i beat accepted this cycle when valid && ready.
- port_rx_data  out  N_PORTS*DATA_W  output j data, registered.
- port_rx_last  out  N_PORTS  output j last flag, registered.
- port_rx_valid  out  N_PORTS  output j beat present, registered.
- port_rx_ready  in  N_PORTS  output j sink accepts the beat.

## Operation
- Requests: input i requests output j when port_tx_valid[i] && port_tx_dest[i]==j. Each input requests at most one output per cycle.
- Output stage j can load when !port_rx_valid[j] || port_rx_ready[j].
- Arbiter j:
  - Round-robin pointer rr_ptr[j] (SEL_W bits).
  - Grants the first requesting input at or after rr_ptr[j], wrapping modulo N_PORTS.
  - port_tx_ready[i] = granted by its destination && that output stage can load.
- On each transfer (valid && ready), the output register loads data, last and valid=1.
- If nothing is transferred and port_rx_ready[j]=1, valid[j] clears.
- rr_ptr[j] advances to (granted index + 1) mod N_PORTS, on the rules given under Configuration.
- Destination out of range (port_tx_dest >= N_PORTS, possible when N_PORTS is not a power of two):
  - The beat is accepted (port_tx_ready=1) and discarded.
  - No output changes.
  - This prevents deadlock.
- Head-of-line blocking is accepted: an input whose destination is busy stalls. There is no per-input buffering.
- Many-to-one traffic: the outputs receive beats interleaved or packetised per Configuration. One-to-one permutations run at full rate with no conflict.

## Timing
- Latency: a beat accepted in cycle t appears on port_rx_* in cycle t+1.
- Throughput: 1 beat/cycle per output while port_rx_ready is held high.
- port_tx_ready is combinational from port_tx_valid, port_tx_dest, port_rx_ready and state. There is no combinational path from port_tx_ready back into the block.
- Beat ordering: beats from one input to one output arrive in order. Data is never duplicated or dropped, except for out-of-range destinations.
- Reset values:
  - port_rx_valid=0, port_rx_last=0, port_rx_data=0.
  - rr_ptr=0, all output FSMs in IDLE.
  - port_tx_ready=0 while rst=1.
- Reset mid-packet:
  - Lock is cleared and any partial packet is abandoned; no trailing beat is emitted.
  - The first cycle after rst deasserts arbitrates normally from input 0.

## Configuration
- Macro XBAR_PKT_LOCK_EN defined:
  - Each output runs FSM IDLE -> LOCKED(i) on a granted beat with last=0.
  - In LOCKED(i), only input i may transfer to that output.
  - A stall or valid gap by input i holds the lock and emits bubbles.
  - LOCKED -> IDLE on the transferred beat with last=1. rr_ptr updates at that point only.
  - A single-beat packet (last=1) never leaves IDLE.
- Macro undefined:
  - No lock FSM; arbitration is per beat and rr_ptr updates on every transfer.
  - port_tx_last is carried through to port_rx_last unchanged but has no control effect.

## Test plan
- Permutation: N_PORTS=4, DATA_W=8; inputs 0..3 send continuously to dest 3,2,1,0 with all rx_ready=1 -> every output receives 1 beat/cycle, with port_rx_data[3] = input 0 data one cycle later.
- Contention round-robin: inputs 0,1,2 send single-beat packets to output 1 every cycle -> grants rotate 0,1,2,0,1,2; each input's port_tx_ready is high 1 cycle in 3.
- Backpressure: output 2 holds data 0xA5 with port_rx_ready[2]=0 for 5 cycles -> 0xA5 stays stable and the requester's port_tx_ready=0; on release, the next beat appears the following cycle.
- Packet lock (XBAR_PKT_LOCK_EN): input 0 sends a 4-beat packet to output 0 while input 3 also requests it -> output 0 carries 4 contiguous beats from input 0 before any beat from input 3. Without the macro, the beats interleave 0,3,0,3.
- Reset mid-packet: assert rst on beat 2 of a locked packet -> next cycle port_rx_valid=0 on all outputs; after release, input 3 wins output 0 immediately if input 0 is idle.
- Out-of-range destination: N_PORTS=3, dest=3 -> port_tx_ready=1 and no port_rx_valid rises.
